// File: rtl/alu_shift_sequencer_if.sv
// Bundle between the sequencer, its decode-side requester and the 32-bit ALU.
// The sequencer is the slave: it takes requests and ALU results and drives the
// ALU operands and the completion/result signals.
interface alu_shift_sequencer_if;
  // Request from decode
  logic        start;
  logic [3:0]  func;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic [4:0]  shamt;
  // ALU connection
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_zero;
  // Completion / status
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        result_zero;
  logic        illegal;

  modport master (
    output start, func, reg_a, reg_b, shamt, alu_out, alu_zero,
    input  alu_a, alu_b, alu_op, busy, done, result, result_zero, illegal
  );

  modport slave (
    input  start, func, reg_a, reg_b, shamt, alu_out, alu_zero,
    output alu_a, alu_b, alu_op, busy, done, result, result_zero, illegal
  );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Execute-stage sequencer around a single-bit-shift 32-bit ALU. Single-cycle
// ALU ops complete after one EXEC cycle; shifts/rotates loop through SHIFT
// once per bit of the requested amount, feeding the ALU output back to A.
// All ALU-facing outputs are registered so the ALU gets a full cycle to settle.
module alu_shift_sequencer (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  alu_shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_e;

  state_e      state_q;
  logic [31:0] w_q;
  logic [31:0] b_q;
  logic [3:0]  f_q;
  logic [4:0]  c_q;
  logic [4:0]  c_d;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_op_q;
  logic [31:0] result_q;
  logic        result_zero_q;
  logic        busy_q;
  logic        done_q;
  logic        illegal_q;

  function automatic logic is_shift(input logic [3:0] f);
    case (f)
      4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [3:0] f);
    case (f)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: return 1'b1;
      default:                                     return is_shift(f);
    endcase
  endfunction

  // Remaining-iteration count after the current SHIFT cycle
  assign c_d = c_q - 5'd1;

  // Sequencer FSM with registered ALU drive and completion outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      w_q           <= '0;
      b_q           <= '0;
      f_q           <= '0;
      c_q           <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      result_q      <= '0;
      result_zero_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          alu_a_q  <= '0;
          alu_b_q  <= '0;
          alu_op_q <= '0;
          if (bus.start) begin
            w_q     <= bus.reg_a;
            b_q     <= bus.reg_b;
            f_q     <= bus.func;
            c_q     <= bus.shamt;
            busy_q  <= 1'b1;
            alu_a_q <= bus.reg_a;
            if (is_shift(bus.func) && (bus.shamt != 5'd0)) begin
              // Single-bit ALU shift: B is unused, op stays fixed per iteration
              alu_b_q  <= '0;
              alu_op_q <= bus.func;
              state_q  <= SHIFT;
            end else begin
              // Illegal codes are never presented to the ALU
              alu_b_q  <= bus.reg_b;
              alu_op_q <= is_legal(bus.func) ? bus.func : 4'b0000;
              state_q  <= EXEC;
            end
          end
        end

        EXEC: begin
          if (!is_legal(f_q)) begin
            result_q      <= '0;
            result_zero_q <= 1'b1;
            illegal_q     <= 1'b1;
          end else if (is_shift(f_q)) begin
            // Zero-amount shift: operand passes through untouched
            result_q      <= w_q;
            result_zero_q <= (w_q == 32'd0);
          end else begin
            result_q      <= bus.alu_out;
            result_zero_q <= bus.alu_zero;
          end
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          alu_a_q  <= '0;
          alu_b_q  <= '0;
          alu_op_q <= '0;
          state_q  <= IDLE;
        end

        SHIFT: begin
          w_q     <= bus.alu_out;
          c_q     <= c_d;
          alu_a_q <= bus.alu_out;
          if (c_q == 5'd1) begin
            result_q      <= bus.alu_out;
            result_zero_q <= bus.alu_zero;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            state_q       <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.result      = result_q;
  assign bus.result_zero = result_zero_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;

endmodule
